// File: rtl/firebird7_in_gate1_tessent_data_capture_w3.sv
// Observe-side IJTAG data register for the firebird7_in gate1 network: it synchronises a
// functional bus into ijtag_tck and exposes a live or sticky-OR snapshot as a capture/shift/update segment.
module firebird7_in_gate1_tessent_data_capture_w3 #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic             sticky_mode,
  output logic             sticky_nonzero
);

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CAPTURE,
    OP_SHIFT,
    OP_UPDATE
  } op_e;

  op_e              op;
  logic [WIDTH+1:0] sr;
  logic [WIDTH+1:0] sr_d;
  logic             mode_d;
  logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sticky_q;
  logic             sticky_clear;

  // Only the highest-priority requested operation runs: capture, then shift, then update.
  always_comb begin
    op = OP_NONE;
    if (ijtag_sel) begin
      if (ijtag_ce)      op = OP_CAPTURE;
      else if (ijtag_se) op = OP_SHIFT;
      else if (ijtag_ue) op = OP_UPDATE;
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
    end else begin
      sync_ff[0] <= functional_data_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  // A clear issued by update wins over whatever synchronised bits arrive on the same edge.
  assign sticky_clear = (op == OP_UPDATE) && sr[WIDTH+1];

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset)      sticky_q <= '0;
    else if (sticky_clear) sticky_q <= '0;
    else                   sticky_q <= sticky_q | sync_q;
  end

  always_comb begin
    sr_d   = sr;
    mode_d = sticky_mode;
    unique case (op)
      OP_CAPTURE: sr_d = {1'b0, sticky_mode, (sticky_mode ? sticky_q : sync_q)};
      OP_SHIFT:   sr_d = {ijtag_si, sr[WIDTH+1:1]};
      OP_UPDATE:  mode_d = sr[WIDTH];
      default:    ;
    endcase
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr          <= '0;
      sticky_mode <= 1'b0;
    end else begin
      sr          <= sr_d;
      sticky_mode <= mode_d;
    end
  end

  assign ijtag_so       = sr[0];
  assign sticky_nonzero = |sticky_q;

endmodule
